// File: rtl/lfsr_action_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_action_gen_if
// Function : Request, reseed and response bundle for lfsr_action_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface lfsr_action_gen_if #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 2
);
    localparam int CH_W = $clog2(N_CH);

    logic             req_valid;
    logic             req_ready;
    logic [CH_W-1:0]  req_ch;
    logic [3:0]       req_type;
    logic             req_is_player;

    logic             seed_load;
    logic [CH_W-1:0]  seed_ch;
    logic [WIDTH-1:0] seed_value;

    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_state;
    logic [CH_W-1:0]  resp_ch;
    logic [7:0]       resp_sample;

    modport master (
        output req_valid, req_ch, req_type, req_is_player,
        output seed_load, seed_ch, seed_value,
        output resp_ready,
        input  req_ready, resp_valid, resp_state, resp_ch, resp_sample
    );

    modport slave (
        input  req_valid, req_ch, req_type, req_is_player,
        input  seed_load, seed_ch, seed_value,
        input  resp_ready,
        output req_ready, resp_valid, resp_state, resp_ch, resp_sample
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_action_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_action_gen
// Function : Per-channel Galois LFSRs mapping action requests to outcomes.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_action_gen #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 'hB400,
    parameter logic [WIDTH-1:0] SEED     = 'hACE1,
    parameter int               N_CH     = 2,
    parameter int               FREE_RUN = 0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    lfsr_action_gen_if.slave  bus
);
    localparam int CH_W = $clog2(N_CH);

    localparam logic [1:0] c_MISS  = 2'd0;
    localparam logic [1:0] c_HIT   = 2'd1;
    localparam logic [1:0] c_CRIT  = 2'd2;
    localparam logic [1:0] c_BLOCK = 2'd3;

    if (WIDTH < 8 || N_CH < 2 || SEED == '0) begin : g_bad_params
        $error("lfsr_action_gen: WIDTH>=8, N_CH>=2 and non-zero SEED required");
    end

    // Channel c resets to SEED rotated left by c bits.
    function automatic logic [WIDTH-1:0] f_reset_seed(input int ch);
        logic [2*WIDTH-1:0] dbl;
        dbl = {SEED, SEED} << (ch % WIDTH);
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : '0);
    endfunction

    // Thresholds are 9 bits wide so 16*15 = 240 never wraps.
    function automatic logic [1:0] f_outcome(input logic [3:0] t,
                                             input logic       pl,
                                             input logic [7:0] r);
        logic [8:0] r9;
        logic [8:0] crit9;
        logic [8:0] hit9;
        r9    = {1'b0, r};
        crit9 = {3'b000, t, 2'b00};
        hit9  = {1'b0, t, 4'b0000};
        if (t == 4'd0)                     return c_MISS;
        else if (r9 < crit9)               return c_CRIT;
        else if (r9 < hit9)                return c_HIT;
        else if (!pl && r9 >= 9'd240)      return c_BLOCK;
        else                               return c_MISS;
    endfunction

    logic [WIDTH-1:0] r_lfsr [N_CH];
    logic [N_CH-1:0]  w_req_hit;
    logic [N_CH-1:0]  w_seed_hit;
    logic [7:0]       w_sample;
    logic             w_req_ch_ok;
    logic             w_req_ready;
    logic             w_accept;
    logic [1:0]       w_state;

    logic             r_resp_valid;
    logic [1:0]       r_resp_state;
    logic [CH_W-1:0]  r_resp_ch;
    logic [7:0]       r_resp_sample;

    // One-hot channel decode; an out-of-range index matches nothing.
    always_comb begin
        w_req_hit  = '0;
        w_seed_hit = '0;
        w_sample   = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_req_hit[c]  = (bus.req_ch  == CH_W'(c));
            w_seed_hit[c] = (bus.seed_ch == CH_W'(c));
            if (bus.req_ch == CH_W'(c)) begin
                w_sample = r_lfsr[c][7:0];
            end
        end
    end

    assign w_req_ch_ok = |w_req_hit;
    assign w_req_ready = !r_resp_valid || bus.resp_ready;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_state     = w_req_ch_ok ? f_outcome(bus.req_type, bus.req_is_player, w_sample)
                                     : c_MISS;

    // A reseed takes priority over a step; a zero reseed falls back to the reset seed.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (reset) begin
                r_lfsr[c] <= f_reset_seed(c);
            end else if (bus.seed_load && w_seed_hit[c]) begin
                r_lfsr[c] <= (bus.seed_value == '0) ? f_reset_seed(c) : bus.seed_value;
            end else if ((FREE_RUN != 0) || (w_accept && w_req_hit[c])) begin
                r_lfsr[c] <= f_step(r_lfsr[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid  <= 1'b0;
            r_resp_state  <= c_MISS;
            r_resp_ch     <= '0;
            r_resp_sample <= '0;
        end else if (w_accept) begin
            r_resp_valid  <= 1'b1;
            r_resp_state  <= w_state;
            r_resp_ch     <= bus.req_ch;
            r_resp_sample <= w_sample;
        end else if (bus.resp_ready) begin
            r_resp_valid  <= 1'b0;
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_state  = r_resp_state;
    assign bus.resp_ch     = r_resp_ch;
    assign bus.resp_sample = r_resp_sample;
endmodule
`default_nettype wire

// File: doc/lfsr_action_gen.md
Name: lfsr_action_gen

Overview:
- Parametrised, multi-channel successor to the game's LFSR outcome generator.
- Each channel (e.g. player, enemy) owns a Galois LFSR. An action request, carrying a channel, an action type and a player/enemy flag, is sampled and mapped to a 2-bit outcome (MISS/HIT/CRIT/BLOCK).
- Outcomes are returned through a valid/ready response register.
- Sits between the game FSM and the combat/score logic, and adds per-channel seeding and backpressure.

Parameters:
- WIDTH, 16, LFSR width; must be ≥ 8.
- TAPS, 16'hB400, Galois feedback mask XORed in when the shifted-out bit is 1.
- SEED, 16'hACE1, base seed; must be non-zero.
- N_CH, 2, number of channels; must be ≥ 2. Localparam CH_W = clog2(N_CH).
- FREE_RUN, 0, 0 = a channel steps only on an accepted request; 1 = all channels step every cycle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  action request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_ch  in  CH_W  channel index.
- req_type  in  4  action strength, 0..15.
- req_is_player  in  1  1 = player action, 0 = enemy action.
- seed_load  in  1  load seed_value into channel seed_ch.
- seed_ch  in  CH_W  channel to reseed.
- seed_value  in  WIDTH  new seed.
- resp_valid  out  1  outcome available.
- resp_ready  in  1  consumer accepts outcome.
- resp_state  out  2  0=MISS, 1=HIT, 2=CRIT, 3=BLOCK.
- resp_ch  out  CH_W  channel of the outcome.
- resp_sample  out  8  sample r used, for debug/scoring.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - lfsr[c] = SEED rotated left by c bits (ch0 = 16'hACE1, ch1 = 16'h59C3).
  - resp_valid=0, resp_state=0, resp_ch=0, resp_sample=0.
  - Reset mid-operation discards any pending response.
- Step (Galois): next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0). Example: ACE1 → E270 → 7138.
- Stepping policy:
  - FREE_RUN=0: only channel req_ch steps, on an accepted request.
  - FREE_RUN=1: all channels step every cycle.
- req_ready = !resp_valid || resp_ready. This is a single-entry output register, with back-to-back throughput of 1 per cycle.
- On accept:
  - Sample r = lfsr[req_ch][7:0], taken before the step.
  - Outcome is registered; resp_valid rises on the next edge (1-cycle latency).
- Outcome mapping, using integer compares at 9-bit width with no wrap:
  - req_type==0 → MISS.
  - else r < 4*type → CRIT.
  - else r < 16*type → HIT.
  - else if !req_is_player && r ≥ 240 → BLOCK.
  - else → MISS.
- resp_* holds stable while resp_valid && !resp_ready.
- resp_valid clears on handshake unless a new request is accepted in the same cycle, in which case the new outcome replaces it.
- seed_load:
  - Writes seed_value to lfsr[seed_ch]; a zero seed_value is replaced by that channel's reset seed (no lock-up).
  - Load beats a step on the same channel in the same cycle.
  - A request accepted in the same cycle still samples the pre-load value.
- Invalid indices: req_ch ≥ N_CH is accepted, with outcome MISS, r=0, and no step. seed_ch ≥ N_CH is ignored.
- Invariant: an LFSR register never holds 0.

Test Plan:
- Reset, then ch0, type 15, player → next cycle resp_valid=1, r=0xE1, HIT (1); lfsr[0] becomes 16'hE270.
- Back-to-back on ch0 with resp_ready=1: type 1 → r=0x70 → MISS; then type 4 → r=0x38 → HIT; lfsr[0] = 16'h7138 then 16'h389C. Throughput is 1 per cycle.
- ch1, type 2, enemy after reset → r=0xC3, MISS. Then seed_load ch1=16'h00F5, followed by ch1, type 3, enemy → r=0xF5 → BLOCK (3).
- Backpressure: resp_ready=0 with a pending outcome → req_ready=0, resp_* stable for 5 cycles, no LFSR step. Releasing resp_ready accepts the queued request on that edge.
- seed_load ch0 with value 0 → lfsr[0] = 16'hACE1; next request type 15 → r=0xE1, HIT. Simultaneous load + request on ch0 → response uses the old sample, and the register takes the loaded value.
- Assert reset while resp_valid=1 and requests are streaming → resp_valid=0 on the next edge; lfsr values are back to ACE1/59C3.
